// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: drives the predictor, looks up a direct-mapped BTB,
// and hands fetch packets downstream over a valid/ready handshake.
module fetch_pc_gen #(
    parameter int          BTB_ENTRIES = 16,
    parameter int          BTB_IDX_W   = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_o,
    input  logic        pred_taken_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_pred_taken_o,
    output logic [31:0] fetch_pred_target_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        btb_wr_en_i,
    input  logic [31:0] btb_wr_pc_i,
    input  logic [31:0] btb_wr_target_i,
    output logic [15:0] redirect_cnt_o
);

    localparam int TAG_W = 30 - BTB_IDX_W;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [15:0]            redirect_cnt_q;
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [29:0]            btb_target_q [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0]   rd_idx, wr_idx;
    logic [TAG_W-1:0]       rd_tag, wr_tag;
    logic                   btb_hit;
    logic                   pred_taken;
    logic [31:0]            pred_target;
    logic [31:0]            seq_pc;
    logic                   transfer;
    logic                   unused_bits;

    // Low two bits of every incoming address are ignored: fetch is word aligned.
    assign unused_bits = ^{redirect_pc_i[1:0], btb_wr_pc_i[1:0], btb_wr_target_i[1:0]};

    assign rd_idx = pc_q[2+BTB_IDX_W-1:2];
    assign rd_tag = pc_q[31:2+BTB_IDX_W];
    assign wr_idx = btb_wr_pc_i[2+BTB_IDX_W-1:2];
    assign wr_tag = btb_wr_pc_i[31:2+BTB_IDX_W];

    // Lookup reads registered BTB contents, so a same-cycle write is seen next cycle.
    assign btb_hit     = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign pred_taken  = btb_hit && pred_taken_i;
    assign seq_pc      = pc_q + 32'd4;
    assign pred_target = pred_taken ? {btb_target_q[rd_idx], 2'b00} : seq_pc;

    assign transfer            = (state_q == RUN) && fetch_ready_i;
    assign pc_o                = pc_q;
    assign fetch_pc_o          = pc_q;
    assign fetch_valid_o       = (state_q == RUN);
    assign fetch_pred_taken_o  = pred_taken;
    assign fetch_pred_target_o = pred_target;
    assign redirect_cnt_o      = redirect_cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            BUBBLE:  state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (transfer) begin
            pc_d = pred_target;
        end
        // A redirect overrides any same-cycle handshake's predicted next PC.
        if (redirect_valid_i) begin
            state_d = BUBBLE;
            pc_d    = {redirect_pc_i[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            redirect_cnt_q <= 16'd0;
            btb_valid_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (redirect_valid_i && (redirect_cnt_q != 16'hFFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
            end
            if (btb_wr_en_i) begin
                btb_valid_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Tag/target storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (btb_wr_en_i) begin
            btb_tag_q[wr_idx]    <= wr_tag;
            btb_target_q[wr_idx] <= btb_wr_target_i[31:2];
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a behavioural next-PC/BTB model checked every cycle.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst;
    logic [31:0] pc_o;
    logic        pred_taken_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_pc_o;
    logic        fetch_pred_taken_o;
    logic [31:0] fetch_pred_target_o;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        btb_wr_en_i;
    logic [31:0] btb_wr_pc_i;
    logic [31:0] btb_wr_target_i;
    logic [15:0] redirect_cnt_o;

    fetch_pc_gen #(
        .BTB_ENTRIES(16),
        .BTB_IDX_W  (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pc_o               (pc_o),
        .pred_taken_i       (pred_taken_i),
        .fetch_valid_o      (fetch_valid_o),
        .fetch_ready_i      (fetch_ready_i),
        .fetch_pc_o         (fetch_pc_o),
        .fetch_pred_taken_o (fetch_pred_taken_o),
        .fetch_pred_target_o(fetch_pred_target_o),
        .redirect_valid_i   (redirect_valid_i),
        .redirect_pc_i      (redirect_pc_i),
        .btb_wr_en_i        (btb_wr_en_i),
        .btb_wr_pc_i        (btb_wr_pc_i),
        .btb_wr_target_i    (btb_wr_target_i),
        .redirect_cnt_o     (redirect_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: the PC, whether this cycle is a no-packet cycle, and a table of installed branches.
    logic [31:0] m_pc;
    logic [31:0] m_next;
    bit          m_quiet;
    int          m_cnt;
    bit          m_bv   [16];
    logic [31:0] m_bpc  [16];
    logic [31:0] m_btgt [16];

    function automatic bit m_taken();
        logic [3:0] i;
        i = m_pc[5:2];
        return pred_taken_i && m_bv[i] && (m_bpc[i][31:2] == m_pc[31:2]);
    endfunction

    function automatic logic [31:0] m_target();
        logic [3:0] i;
        i = m_pc[5:2];
        return m_taken() ? m_btgt[i] : m_pc + 32'd4;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pc    = 32'h0000_0000;
                m_quiet = 1'b1;
                m_cnt   = 0;
                for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
            end else begin
                m_next = m_pc;
                if (redirect_valid_i) m_next = redirect_pc_i & ~32'h3;
                else if (!m_quiet && fetch_ready_i) m_next = m_target();
                if (btb_wr_en_i) begin
                    m_bv[btb_wr_pc_i[5:2]]   = 1'b1;
                    m_bpc[btb_wr_pc_i[5:2]]  = btb_wr_pc_i;
                    m_btgt[btb_wr_pc_i[5:2]] = btb_wr_target_i & ~32'h3;
                end
                m_quiet = redirect_valid_i;
                if (redirect_valid_i && m_cnt < 65535) m_cnt++;
                m_pc = m_next;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_pc_o", pc_o, m_pc);
                check("m_fetch_pc", fetch_pc_o, m_pc);
                check("m_valid", {31'b0, fetch_valid_o}, {31'b0, !m_quiet});
                check("m_taken", {31'b0, fetch_pred_taken_o}, {31'b0, m_taken()});
                check("m_target", fetch_pred_target_o, m_target());
                check("m_cnt", {16'b0, redirect_cnt_o}, m_cnt[31:0]);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; fetch_ready_i = 1'b1; pred_taken_i = 1'b0;
        redirect_valid_i = 1'b0; redirect_pc_i = '0;
        btb_wr_en_i = 1'b0; btb_wr_pc_i = '0; btb_wr_target_i = '0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        neg();
        check("rst_pc", pc_o, 32'h0);
        check("rst_valid", {31'b0, fetch_valid_o}, 32'h0);
        check("rst_target", fetch_pred_target_o, 32'h4);
        check("rst_cnt", {16'b0, redirect_cnt_o}, 32'h0);
        nxt(); rst = 1'b0;

        // Sequential fetch after reset release
        neg(); check("boot_valid", {31'b0, fetch_valid_o}, 32'h0);
        nxt(); neg(); check("seq_valid", {31'b0, fetch_valid_o}, 32'h1);
        check("seq_pc0", fetch_pc_o, 32'h0);
        nxt(); neg(); check("seq_pc4", fetch_pc_o, 32'h4);
        nxt();

        // Three stalled edges at 0x8
        fetch_ready_i = 1'b0;
        neg(); check("stall_pc_a", pc_o, 32'h8);
        nxt(); neg(); check("stall_pc_b", pc_o, 32'h8);
        check("stall_valid", {31'b0, fetch_valid_o}, 32'h1);
        nxt(); neg(); check("stall_pc_c", pc_o, 32'h8);
        nxt(); fetch_ready_i = 1'b1;
        neg(); check("stall_release_pc", fetch_pc_o, 32'h8);
        nxt(); neg(); check("after_stall_pc", fetch_pc_o, 32'hC);

        // Install 0x10 -> 0x100, taken
        btb_wr_en_i = 1'b1; btb_wr_pc_i = 32'h10; btb_wr_target_i = 32'h100;
        nxt(); btb_wr_en_i = 1'b0; pred_taken_i = 1'b1;
        neg(); check("hit_pc", fetch_pc_o, 32'h10);
        check("hit_taken", {31'b0, fetch_pred_taken_o}, 32'h1);
        check("hit_target", fetch_pred_target_o, 32'h100);
        nxt(); pred_taken_i = 1'b0;
        neg(); check("taken_next_pc", fetch_pc_o, 32'h100);

        // Redirect during a handshake
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h203;
        nxt(); redirect_valid_i = 1'b0;
        neg(); check("redir_pc", pc_o, 32'h200);
        check("redir_bubble", {31'b0, fetch_valid_o}, 32'h0);
        check("redir_cnt", {16'b0, redirect_cnt_o}, 32'h1);
        nxt(); neg(); check("redir_pkt", {31'b0, fetch_valid_o}, 32'h1);

        // Hit but predictor says not taken
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h10;
        nxt(); redirect_valid_i = 1'b0;
        nxt(); neg(); check("nt_taken", {31'b0, fetch_pred_taken_o}, 32'h0);
        check("nt_target", fetch_pred_target_o, 32'h14);
        nxt(); neg(); check("nt_next_pc", fetch_pc_o, 32'h14);

        // Aliasing and same-cycle write/lookup
        btb_wr_en_i = 1'b1; btb_wr_pc_i = 32'h50; btb_wr_target_i = 32'h300;
        nxt(); btb_wr_en_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h10;
        nxt(); redirect_valid_i = 1'b0;
        nxt(); pred_taken_i = 1'b1; fetch_ready_i = 1'b0;
        btb_wr_en_i = 1'b1; btb_wr_pc_i = 32'h10; btb_wr_target_i = 32'h180;
        neg(); check("alias_miss", {31'b0, fetch_pred_taken_o}, 32'h0);
        check("alias_target", fetch_pred_target_o, 32'h14);
        nxt(); btb_wr_en_i = 1'b0; fetch_ready_i = 1'b1;
        neg(); check("wr_visible_next", {31'b0, fetch_pred_taken_o}, 32'h1);
        check("wr_visible_target", fetch_pred_target_o, 32'h180);
        nxt(); neg(); check("wr_taken_pc", fetch_pc_o, 32'h180);

        // BTB write in a redirect cycle, then reset mid-stream at 0x40
        btb_wr_en_i = 1'b1; btb_wr_pc_i = 32'h40; btb_wr_target_i = 32'h400;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
        nxt(); btb_wr_en_i = 1'b0; redirect_valid_i = 1'b0;
        nxt(); neg(); check("pre_rst_taken", {31'b0, fetch_pred_taken_o}, 32'h1);
        check("pre_rst_target", fetch_pred_target_o, 32'h400);
        fetch_ready_i = 1'b0;
        nxt(); rst = 1'b1;
        #1;
        check("async_rst_pc", pc_o, 32'h0);
        check("async_rst_valid", {31'b0, fetch_valid_o}, 32'h0);
        check("async_rst_cnt", {16'b0, redirect_cnt_o}, 32'h0);
        nxt(); rst = 1'b0; fetch_ready_i = 1'b1;
        neg(); check("rst_boot_valid", {31'b0, fetch_valid_o}, 32'h0);
        nxt(); neg(); check("rst_run_valid", {31'b0, fetch_valid_o}, 32'h1);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
        nxt(); redirect_valid_i = 1'b0;
        nxt(); neg(); check("btb_cleared", {31'b0, fetch_pred_taken_o}, 32'h0);
        check("btb_cleared_cnt", {16'b0, redirect_cnt_o}, 32'h1);

        // Back-to-back redirects
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h500;
        nxt(); redirect_pc_i = 32'h600;
        nxt(); redirect_valid_i = 1'b0;
        neg(); check("b2b_pc", pc_o, 32'h600);
        check("b2b_bubble", {31'b0, fetch_valid_o}, 32'h0);
        nxt(); neg(); check("b2b_pkt", {31'b0, fetch_valid_o}, 32'h1);

        // PC+4 wraps at the top of the address space
        pred_taken_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        nxt(); redirect_valid_i = 1'b0;
        nxt(); neg(); check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_target", fetch_pred_target_o, 32'h0);
        nxt(); neg(); check("wrap_next_pc", pc_o, 32'h0);

        // Redirect counter saturation
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h1000;
        repeat (65540) nxt();
        redirect_valid_i = 1'b0;
        neg(); check("cnt_sat", {16'b0, redirect_cnt_o}, 32'hFFFF);
        nxt(); neg(); check("cnt_sat_hold", {16'b0, redirect_cnt_o}, 32'hFFFF);
        repeat (2) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
